// File: rtl/command_control_hub_gen.sv
`default_nettype none
// ============================================================================
// Module   : command_control_hub_gen
// Purpose  : Port-mapped I/O hub for the PicoBlaze command-and-control
//            processor. Serves the LogCap register bank, UART FIFOs, LEDs,
//            switches and buttons. Adds a programmable millisecond timer,
//            latched button edges and a masked, cause-tracked interrupt with
//            an interrupt/interrupt_ack handshake.
// Ports    : clk, reset (async, active-low)
//            port_id/port_out/port_in, write_strobe/read_strobe  - CPU bus
//            interrupt/interrupt_ack                             - IRQ pair
//            data_out, urx_* , urx_buffer_read                   - UART RX
//            data_in, utx_*, utx_buffer_write                    - UART TX
//            regIn/regOut, command/command_strobe, status        - LogCap
//            led, switch, button                                 - board I/O
// Revision : 1.0 - initial release
// ============================================================================
module command_control_hub_gen #(
  parameter int NUM_REGS          = 8,
  parameter int CLK_HZ            = 100_000_000,
  parameter int DEFAULT_PERIOD_MS = 1000,
  parameter int NUM_BUTTONS       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [15:0]              led,
  input  logic [NUM_BUTTONS-1:0]   button,
  input  logic [15:0]              switch,
  output logic                     interrupt,
  input  logic                     interrupt_ack,
  input  logic [7:0]               port_id,
  input  logic [7:0]               port_out,
  output logic [7:0]               port_in,
  input  logic                     write_strobe,
  input  logic                     read_strobe,
  input  logic [7:0]               data_out,
  input  logic                     urx_buffer_full,
  input  logic                     urx_buffer_half_full,
  input  logic                     urx_buffer_data_present,
  output logic                     urx_buffer_read,
  output logic [7:0]               data_in,
  input  logic                     utx_buffer_full,
  input  logic                     utx_buffer_half_full,
  input  logic                     utx_buffer_data_present,
  output logic                     utx_buffer_write,
  input  logic [8*NUM_REGS-1:0]    regIn,
  output logic [8*NUM_REGS-1:0]    regOut,
  output logic [7:0]               command,
  output logic                     command_strobe,
  input  logic [7:0]               status
);

  // Prescaler terminal count for a 1 ms tick.
  localparam int c_PRESC     = CLK_HZ / 1000;
  localparam int c_PRESC_MAX = (c_PRESC > 1) ? c_PRESC - 1 : 0;
  localparam int c_PRESC_W   = (c_PRESC_MAX > 0) ? $clog2(c_PRESC_MAX + 1) : 1;

  localparam logic [7:0] c_A_STATUS = 8'h10;  // read status / write command
  localparam logic [7:0] c_A_UART   = 8'h11;
  localparam logic [7:0] c_A_12     = 8'h12;  // read uart flags / write led lo
  localparam logic [7:0] c_A_13     = 8'h13;  // read switch lo / write led hi
  localparam logic [7:0] c_A_14     = 8'h14;  // read switch hi / write period lo
  localparam logic [7:0] c_A_15     = 8'h15;  // read buttons / write period hi
  localparam logic [7:0] c_A_16     = 8'h16;  // read edge latch / write mask
  localparam logic [7:0] c_A_17     = 8'h17;  // read cause / write cause W1C
  localparam logic [7:0] c_A_18     = 8'h18;  // read mask

  // --------------------------------------------------------------------------
  // Register bank
  // --------------------------------------------------------------------------
  logic       w_wr_reg;
  logic [7:0] w_reg_in [16];

  assign w_wr_reg = write_strobe && (port_id[7:4] == 4'h0) &&
                    ({1'b0, port_id[3:0]} < 5'(NUM_REGS));

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regout
    logic [7:0] r_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                   r_reg <= '0;
      else if (w_wr_reg && port_id[3:0] == 4'(k))   r_reg <= port_out;
    end
    assign regOut[8*k +: 8] = r_reg;
  end

  // Unpopulated slots read back as zero.
  for (genvar k = 0; k < 16; k++) begin : g_regin
    if (k < NUM_REGS) begin : g_used
      assign w_reg_in[k] = regIn[8*k +: 8];
    end else begin : g_unused
      assign w_reg_in[k] = 8'h00;
    end
  end

  // --------------------------------------------------------------------------
  // Buttons: two-flop synchronizer, a third flop for edge detection
  // --------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] r_btn_meta, r_btn_sync, r_btn_prev, r_btn_latch;
  logic [NUM_BUTTONS-1:0] w_btn_rise;
  logic                   w_latch_clr;

  assign w_btn_rise  = r_btn_sync & ~r_btn_prev;
  assign w_latch_clr = read_strobe && (port_id == c_A_16);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_meta  <= '0;
      r_btn_sync  <= '0;
      r_btn_prev  <= '0;
      r_btn_latch <= '0;
    end else begin
      r_btn_meta  <= button;
      r_btn_sync  <= r_btn_meta;
      r_btn_prev  <= r_btn_sync;
      // An edge arriving with the clear is OR-ed in after clearing.
      r_btn_latch <= (w_latch_clr ? '0 : r_btn_latch) | w_btn_rise;
    end
  end

  // --------------------------------------------------------------------------
  // Timer
  // --------------------------------------------------------------------------
  logic [15:0]          r_period, r_ms;
  logic [c_PRESC_W-1:0] r_presc;
  logic                 w_period_wr, w_tick, w_fire;

  assign w_period_wr = write_strobe && (port_id == c_A_14 || port_id == c_A_15);
  assign w_tick      = (r_presc == c_PRESC_W'(c_PRESC_MAX));
  assign w_fire      = (r_period != 16'd0) && w_tick && (r_ms == r_period - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period <= 16'(DEFAULT_PERIOD_MS);
      r_presc  <= '0;
      r_ms     <= '0;
    end else begin
      if (write_strobe && port_id == c_A_14) r_period[7:0]  <= port_out;
      if (write_strobe && port_id == c_A_15) r_period[15:8] <= port_out;
      if (w_period_wr || r_period == 16'd0) begin
        r_presc <= '0;
        r_ms    <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_ms    <= (r_ms == r_period - 16'd1) ? 16'd0 : r_ms + 16'd1;
      end else begin
        r_presc <= r_presc + c_PRESC_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt causes, mask and handshake
  // --------------------------------------------------------------------------
  logic [3:0] r_cause, r_mask, w_cause_set, w_cause_clr, w_mask_new;
  logic       r_urx_prev, r_stat0_prev, r_irq, w_mask_wr, w_irq_event;

  assign w_cause_set = {status[0] & ~r_stat0_prev,
                        urx_buffer_data_present & ~r_urx_prev,
                        |w_btn_rise,
                        w_fire};
  assign w_cause_clr = (write_strobe && port_id == c_A_17) ? port_out[3:0] : 4'h0;
  assign w_mask_wr   = write_strobe && (port_id == c_A_16);
  // Bits newly enabled by a mask write whose cause is already pending.
  assign w_mask_new  = w_mask_wr ? (port_out[3:0] & ~r_mask & r_cause) : 4'h0;
  assign w_irq_event = (|(w_cause_set & r_mask)) || (|w_mask_new);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cause      <= '0;
      r_mask       <= '0;
      r_urx_prev   <= 1'b0;
      r_stat0_prev <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_cause      <= (r_cause & ~w_cause_clr) | w_cause_set;  // set wins
      r_urx_prev   <= urx_buffer_data_present;
      r_stat0_prev <= status[0];
      if (w_mask_wr)          r_mask <= port_out[3:0];
      // A qualifying event outranks the ack so it is never lost.
      if (w_irq_event)        r_irq  <= 1'b1;
      else if (interrupt_ack) r_irq  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux, output registers, UART strobes
  // --------------------------------------------------------------------------
  logic [7:0]  w_rd_data, r_port_in, r_command;
  logic [15:0] r_led;
  logic        r_cmd_strobe, r_urx_read;

  always_comb begin
    w_rd_data = 8'h00;
    if (port_id[7:4] == 4'h0) begin
      w_rd_data = w_reg_in[port_id[3:0]];
    end else begin
      case (port_id)
        c_A_STATUS: w_rd_data = status;
        c_A_UART:   w_rd_data = data_out;
        c_A_12:     w_rd_data = {2'b00, urx_buffer_full, urx_buffer_half_full,
                                 urx_buffer_data_present, utx_buffer_full,
                                 utx_buffer_half_full, utx_buffer_data_present};
        c_A_13:     w_rd_data = switch[7:0];
        c_A_14:     w_rd_data = switch[15:8];
        c_A_15:     w_rd_data = 8'(r_btn_sync);
        c_A_16:     w_rd_data = 8'(r_btn_latch);
        c_A_17:     w_rd_data = {4'h0, r_cause};
        c_A_18:     w_rd_data = {4'h0, r_mask};
        default:    w_rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_in    <= '0;
      r_command    <= '0;
      r_led        <= '0;
      r_cmd_strobe <= 1'b0;
      r_urx_read   <= 1'b0;
    end else begin
      r_port_in    <= w_rd_data;
      r_cmd_strobe <= write_strobe && (port_id == c_A_STATUS);
      r_urx_read   <= read_strobe && (port_id == c_A_UART);
      if (write_strobe && port_id == c_A_STATUS) r_command   <= port_out;
      if (write_strobe && port_id == c_A_12)     r_led[7:0]  <= port_out;
      if (write_strobe && port_id == c_A_13)     r_led[15:8] <= port_out;
    end
  end

  assign port_in          = r_port_in;
  assign command          = r_command;
  assign command_strobe   = r_cmd_strobe;
  assign led              = r_led;
  assign urx_buffer_read  = r_urx_read;
  assign interrupt        = r_irq;
  assign utx_buffer_write = write_strobe && (port_id == c_A_UART);
  assign data_in          = port_out;

endmodule
`default_nettype wire

// File: doc/command_control_hub_gen.md
# command_control_hub_gen

Parametrised port-mapped I/O hub between the PicoBlaze command-and-control processor and the rest of the design. It serves a configurable-depth LogCap register bank, the UART FIFOs, the board LEDs, switches and buttons. It adds a programmable periodic timer, latched button edges, and a masked, cause-tracked interrupt with a full `interrupt`/`interrupt_ack` handshake.

## Interface
- `NUM_REGS`, 8: LogCap register pairs, 1..16.
- `CLK_HZ`, 100_000_000: clock frequency in Hz.
- `DEFAULT_PERIOD_MS`, 1000: timer period after reset, in ms.
- `NUM_BUTTONS`, 8: button inputs, 1..8.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `led` out 16: LED drive.
- `button` in NUM_BUTTONS: asynchronous buttons.
- `switch` in 16: switches.
- `interrupt` out 1; `interrupt_ack` in 1.
- `port_id` in 8; `port_out` in 8; `port_in` out 8.
- `write_strobe`, `read_strobe` in 1.
- `data_out` in 8; `urx_buffer_full`, `urx_buffer_half_full`, `urx_buffer_data_present` in 1; `urx_buffer_read` out 1.
- `data_in` out 8; `utx_buffer_full`, `utx_buffer_half_full`, `utx_buffer_data_present` in 1; `utx_buffer_write` out 1.
- `regIn` in 8*NUM_REGS: byte k at [8k+7:8k].
- `regOut` out 8*NUM_REGS: same packing.
- `command` out 8; `command_strobe` out 1.
- `status` in 8: LogCap status.

## Operation
- Full 8-bit decode of `port_id`.
- **Read map**
  - 0x00–0x0F: regIn[k]; reads 0x00 for k ≥ NUM_REGS.
  - 0x10: status.
  - 0x11: data_out.
  - 0x12: {2'b0, urx full, urx half, urx present, utx full, utx half, utx present}.
  - 0x13: switch[7:0]. 0x14: switch[15:8].
  - 0x15: synchronized buttons, zero-extended.
  - 0x16: button edge latch.
  - 0x17: {4'b0, cause[3:0]}.
  - 0x18: mask.
  - Any other address reads 0x00.
- **Write map**
  - 0x00–0x0F: regOut[k]; ignored for k ≥ NUM_REGS.
  - 0x10: command, plus a strobe pulse.
  - 0x11: UART TX.
  - 0x12: led[7:0]. 0x13: led[15:8].
  - 0x14: period[7:0]. 0x15: period[15:8].
  - 0x16: mask[3:0].
  - 0x17: cause W1C (write 1 to clear).
  - Other addresses: no effect.
- **Buttons**
  - Two-flop synchronizer.
  - A rising edge sets the corresponding bit of the edge latch.
  - `read_strobe` at 0x16 clears the latch.
  - An edge in the same cycle as the clear is retained.
- **Timer**
  - Prescaler counts 0..CLK_HZ/1000−1 to produce a 1 ms tick.
  - 16-bit ms counter fires when it reaches period−1, then wraps to 0.
  - period = 0 disables the timer (counters held at 0).
  - A write to 0x14 or 0x15 resets both counters.
- **Interrupt causes** (sticky bits):
  - bit0: timer fire.
  - bit1: any new button edge.
  - bit2: rising edge of `urx_buffer_data_present`.
  - bit3: rising edge of status[0].
  - Set wins over a simultaneous W1C clear.
- **Interrupt handshake**
  - `interrupt` rises the cycle after any cause bit is newly set while its mask bit is 1.
  - It also rises the cycle after a mask write enables a bit whose cause is already pending.
  - It stays high until `interrupt_ack`, then drops on the next cycle.
  - A new qualifying event in the ack cycle re-raises it one cycle later.
  - Pending causes do not re-raise the interrupt by themselves.

## Timing
- Reset values:
  - led, regOut, command, port_in, mask, cause, edge latch, counters: 0.
  - period: DEFAULT_PERIOD_MS.
  - command_strobe, urx_buffer_read, interrupt: 0.
- `port_in`: registered from `port_id` every cycle, valid one cycle after `port_id` settles.
- Register and LED writes: visible the cycle after `write_strobe`.
- `command_strobe`: exactly one cycle, the cycle after the write. Back-to-back writes give back-to-back pulses, with command updated each time.
- `utx_buffer_write = write_strobe && port_id==0x11`, combinational; `data_in = port_out`.
- `urx_buffer_read`: one-cycle pulse, the cycle after `read_strobe` at 0x11.
- Asserting `reset` mid-operation forces all outputs to their reset values immediately and aborts any pending strobe.

## Test plan
- **Reset and registers:** release reset; write 0xA5 to 0x03 and 0x5A to 0x0F with NUM_REGS=8.
  - regOut[31:24]=0xA5; regOut unchanged by the 0x0F write.
  - Read 0x0F → 0x00.
- **Command strobe:** writes 0x01 then 0x02 at 0x10 on consecutive cycles → two consecutive strobe pulses, command 0x01 then 0x02.
- **UART:** `read_strobe` at 0x11 → one-cycle `urx_buffer_read`, port_in=data_out. Write 0x41 at 0x11 → same-cycle `utx_buffer_write`, data_in=0x41.
- **Timer:** CLK_HZ=10_000, period=3.
  - cause[0] sets every 30 cycles.
  - Writing period=0 stops it.
  - Mask=1 → interrupt high until ack, low the next cycle.
- **Button latch:** pulse button[2].
  - Read 0x16 → 0x04, then 0x00 on the next read.
  - An edge coincident with the read-clear stays latched.
- **Cause W1C:** W1C of cause[1] in the same cycle as a new button edge → cause[1] remains 1, interrupt re-raised if mask[1]=1.
